// File: rtl/digit_seg_source.sv
// rtl/digit_seg_source.sv - debounced up/down decimal digit driving a 7-segment register load
module digit_seg_source #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       clear,
  output logic [6:0] seg,
  output logic       load,
  output logic [3:0] digit
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LOAD} state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Bit 0 of every per-button vector is the up button, bit 1 the down button.
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           lvl_q, lvl_d;
  logic [1:0]           lvl_prev_q, lvl_prev_d;
  logic [1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [1:0]           press;

  state_t     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic [6:0] seg_q, seg_d;
  logic       load_q, load_d;
  logic       pend_up_q, pend_up_d;
  logic       pend_dn_q, pend_dn_d;
  logic       pend_clr_q, pend_clr_d;
  logic       want_up, want_dn, want_clr;
  logic       accept;
  logic [3:0] next_digit;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h3F;
    endcase
  endfunction

  // Two-flop synchronisers feeding a per-button stability counter.
  always_comb begin
    sync1_d    = {btn_down, btn_up};
    sync2_d    = sync1_q;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          lvl_d[i] = ~lvl_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // A press is the cycle right after the debounced level rises; releases are ignored.
  assign press = lvl_q & ~lvl_prev_q;

  // Digit FSM: presses/clears that cannot be served right now stay pending.
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    seg_d      = seg_q;
    load_d     = 1'b0;
    pend_up_d  = pend_up_q | press[0];
    pend_dn_d  = pend_dn_q | press[1];
    pend_clr_d = pend_clr_q | clear;
    want_up    = pend_up_q | press[0];
    want_dn    = pend_dn_q | press[1];
    want_clr   = pend_clr_q | clear;
    accept     = 1'b0;
    next_digit = digit_q;
    case (state_q)
      ST_INIT: begin
        digit_d = 4'd0;
        seg_d   = 7'h3F;
        load_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // The first IDLE cycle after INIT still has load high; wait one cycle so load never doubles.
        if (!load_q) begin
          pend_up_d  = 1'b0;
          pend_dn_d  = 1'b0;
          pend_clr_d = 1'b0;
          if (want_clr) begin
            next_digit = 4'd0;
            accept     = 1'b1;
          end else if (want_up && !want_dn) begin
            next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            accept     = 1'b1;
          end else if (want_dn && !want_up) begin
            next_digit = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            accept     = 1'b1;
          end
          if (accept) begin
            digit_d = next_digit;
            seg_d   = seg_of(next_digit);
            load_d  = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // All state clears asynchronously on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      cnt_q      <= '0;
      state_q    <= ST_INIT;
      digit_q    <= 4'd0;
      seg_q      <= 7'h3F;
      load_q     <= 1'b0;
      pend_up_q  <= 1'b0;
      pend_dn_q  <= 1'b0;
      pend_clr_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      load_q     <= load_d;
      pend_up_q  <= pend_up_d;
      pend_dn_q  <= pend_dn_d;
      pend_clr_q <= pend_clr_d;
    end
  end

  assign seg   = seg_q;
  assign load  = load_q;
  assign digit = digit_q;

endmodule

// File: tb/tb_digit_seg_source.sv
// tb/tb_digit_seg_source.sv - scoreboard bench for digit_seg_source
module tb_digit_seg_source;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic       load;
  logic [3:0] digit;

  typedef struct packed {
    logic [3:0] d;
    logic [6:0] s;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   loads_seen = 0;
  int   model_digit = 0;
  logic prev_load = 1'b0;

  digit_seg_source #(.DB_CYCLES(DB), .DB_W(16)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .clear(clear),
    .seg(seg), .load(load), .digit(digit)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: seg_ref = 7'h3F;
      1: seg_ref = 7'h06;
      2: seg_ref = 7'h5B;
      3: seg_ref = 7'h4F;
      4: seg_ref = 7'h66;
      5: seg_ref = 7'h6D;
      6: seg_ref = 7'h7D;
      7: seg_ref = 7'h07;
      8: seg_ref = 7'h7F;
      9: seg_ref = 7'h6F;
      default: seg_ref = 7'h00;
    endcase
  endfunction

  function automatic void push_exp(input int d);
    exp_t e;
    e.d = 4'(d);
    e.s = seg_ref(d);
    exp_q.push_back(e);
  endfunction

  // Every load pulse pops one expected {digit, seg} from the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (load) begin
        loads_seen++;
        n_checks++;
        if (prev_load) begin
          n_fail++;
          $display("FAIL load_back_to_back: load high two cycles at %0t", $time);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_load: digit=%0d seg=%h with empty scoreboard", digit, seg);
        end else begin
          mon_e = exp_q.pop_front();
          if ({digit, seg} !== {mon_e.d, mon_e.s}) begin
            n_fail++;
            $display("FAIL load_value: got digit=%0d seg=%h expected digit=%0d seg=%h",
                     digit, seg, mon_e.d, mon_e.s);
          end
        end
      end
      prev_load = load;
    end else begin
      prev_load = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d);
    @(negedge clk);
    btn_up   = u;
    btn_down = d;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(DB + 8);
  endtask

  task automatic press_up();
    model_digit = (model_digit + 1) % 10;
    push_exp(model_digit);
    press(1'b1, 1'b0);
  endtask

  task automatic press_down();
    model_digit = (model_digit + 9) % 10;
    push_exp(model_digit);
    press(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    tick(2);
    n_checks++;
    if ({load, seg, digit} !== {1'b0, 7'h3F, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got load=%b seg=%h digit=%0d expected 0/3f/0", load, seg, digit);
    end
    push_exp(0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (load !== 1'b1 || seg !== 7'h3F) begin
      n_fail++;
      $display("FAIL init_load: got load=%b seg=%h expected 1/3f", load, seg);
    end
    @(negedge clk);
    n_checks++;
    if (load !== 1'b0 || digit !== 4'd0) begin
      n_fail++;
      $display("FAIL init_after: got load=%b digit=%0d expected 0/0", load, digit);
    end
    tick(3);
  endtask

  task automatic test_glitch();
    int l0;
    l0 = loads_seen;
    @(negedge clk);
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    tick(12);
    n_checks++;
    if (loads_seen !== l0 || digit !== 4'd0) begin
      n_fail++;
      $display("FAIL glitch: got loads=%0d digit=%0d expected loads=%0d digit=0", loads_seen, digit, l0);
    end
  endtask

  task automatic test_latency();
    int found;
    found = -1;
    model_digit = 1;
    push_exp(1);
    @(negedge clk);
    btn_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (load === 1'b1 && found < 0) found = k;
    end
    btn_up = 1'b0;
    tick(DB + 8);
    n_checks++;
    if (found != DB + 3) begin
      n_fail++;
      $display("FAIL press_latency: got %0d cycles expected %0d", found, DB + 3);
    end
    n_checks++;
    if (digit !== 4'd1 || seg !== 7'h06) begin
      n_fail++;
      $display("FAIL first_press: got digit=%0d seg=%h expected 1/06", digit, seg);
    end
  endtask

  task automatic test_wrap();
    repeat (8) press_up();
    n_checks++;
    if (digit !== 4'd9) begin
      n_fail++;
      $display("FAIL count_to_9: got %0d expected 9", digit);
    end
    press_up();
    n_checks++;
    if (digit !== 4'd0 || seg !== 7'h3F) begin
      n_fail++;
      $display("FAIL wrap_up: got digit=%0d seg=%h expected 0/3f", digit, seg);
    end
    press_down();
    n_checks++;
    if (digit !== 4'd9 || seg !== 7'h6F) begin
      n_fail++;
      $display("FAIL wrap_down: got digit=%0d seg=%h expected 9/6f", digit, seg);
    end
  endtask

  task automatic test_simultaneous();
    int l0;
    l0 = loads_seen;
    press(1'b1, 1'b1);
    n_checks++;
    if (loads_seen !== l0 || digit !== 4'(model_digit)) begin
      n_fail++;
      $display("FAIL both_pressed: got loads=%0d digit=%0d expected loads=%0d digit=%0d",
               loads_seen, digit, l0, model_digit);
    end
  endtask

  task automatic test_back_to_back();
    int l0;
    l0 = loads_seen;
    push_exp((model_digit + 1) % 10);
    push_exp(model_digit);
    @(negedge clk);
    btn_up = 1'b1;
    @(negedge clk);
    btn_down = 1'b1;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(DB + 8);
    n_checks++;
    if (loads_seen !== l0 + 2 || digit !== 4'(model_digit)) begin
      n_fail++;
      $display("FAIL staggered_press: got loads=%0d digit=%0d expected loads=%0d digit=%0d",
               loads_seen - l0, digit, 2, model_digit);
    end
  endtask

  task automatic test_clear();
    int l0;
    int found;
    repeat (4) press_down();
    n_checks++;
    if (digit !== 4'd5) begin
      n_fail++;
      $display("FAIL reach_5: got %0d expected 5", digit);
    end
    model_digit = 0;
    push_exp(0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if ({load, seg, digit} !== {1'b1, 7'h3F, 4'd0}) begin
      n_fail++;
      $display("FAIL clear_idle: got load=%b seg=%h digit=%0d expected 1/3f/0", load, seg, digit);
    end
    tick(3);
    // clear arriving while LOAD is active must be held and served afterwards
    l0 = loads_seen;
    found = 0;
    push_exp(1);
    push_exp(0);
    @(negedge clk);
    btn_up = 1'b1;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (load === 1'b1) found = 1;
    end
    n_checks++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL clear_load_timeout: got no load in 20 cycles expected one");
    end
    clear = 1'b1;
    @(negedge clk);
    clear  = 1'b0;
    btn_up = 1'b0;
    tick(DB + 8);
    n_checks++;
    if (loads_seen !== l0 + 2 || digit !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_in_load: got loads=%0d digit=%0d expected 2/0", loads_seen - l0, digit);
    end
  endtask

  task automatic test_async_reset();
    int found;
    found = 0;
    model_digit = 1;
    push_exp(1);
    @(negedge clk);
    btn_up = 1'b1;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (load === 1'b1) found = 1;
    end
    n_checks++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL reset_load_timeout: got no load in 20 cycles expected one");
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({load, seg, digit} !== {1'b0, 7'h3F, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got load=%b seg=%h digit=%0d expected 0/3f/0", load, seg, digit);
    end
    btn_up = 1'b0;
    model_digit = 0;
    tick(2);
    push_exp(0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (load !== 1'b1 || seg !== 7'h3F) begin
      n_fail++;
      $display("FAIL reinit_load: got load=%b seg=%h expected 1/3f", load, seg);
    end
    tick(DB + 8);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glitch();
    test_latency();
    test_wrap();
    test_simultaneous();
    test_back_to_back();
    test_clear();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
